// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by an on-chip RAM: INCR bursts, one transaction in flight,
// alternating write/read priority when both address channels request together.
module axi_sram_slave #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_AW         = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axi_aw_valid_i,
    output logic                        s_axi_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_aw_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_aw_id_i,
    input  logic [7:0]                  s_axi_aw_len_i,
    input  logic                        s_axi_w_valid_i,
    output logic                        s_axi_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_w_strb_i,
    input  logic                        s_axi_w_last_i,
    output logic                        s_axi_b_valid_o,
    input  logic                        s_axi_b_ready_i,
    output logic [1:0]                  s_axi_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_b_id_o,
    input  logic                        s_axi_ar_valid_i,
    output logic                        s_axi_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_ar_id_i,
    input  logic [7:0]                  s_axi_ar_len_i,
    output logic                        s_axi_r_valid_o,
    input  logic                        s_axi_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_r_data_o,
    output logic [1:0]                  s_axi_r_resp_o,
    output logic                        s_axi_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_r_id_o,
    output logic [1:0]                  state_dbg
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    prio_w;
    logic [MEM_AW-1:0]       idx;
    logic [7:0]              len;
    logic [8:0]              cnt;
    logic [8:0]              cnt_inc;
    logic                    in_burst;
    logic                    aw_grant;
    logic                    aw_hs;
    logic                    ar_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    r_hs;
    logic [MEM_AW-1:0]       aw_idx;
    logic [MEM_AW-1:0]       ar_idx;
    logic [AXI_DATA_WIDTH-1:0] mem [2**MEM_AW];

    // Valid/ready: a beat moves on the rising edge where both valid and ready are high;
    // a valid, once raised, holds its payload stable until that edge.
    assign aw_hs    = s_axi_aw_valid_i & s_axi_aw_ready_o;
    assign ar_hs    = s_axi_ar_valid_i & s_axi_ar_ready_o;
    assign w_hs     = s_axi_w_valid_i  & s_axi_w_ready_o;
    assign b_hs     = s_axi_b_valid_o  & s_axi_b_ready_i;
    assign r_hs     = s_axi_r_valid_o  & s_axi_r_ready_i;
    assign aw_grant = s_axi_aw_valid_i & (~s_axi_ar_valid_i | prio_w);
    assign aw_idx   = s_axi_aw_addr_i[OFF +: MEM_AW];
    assign ar_idx   = s_axi_ar_addr_i[OFF +: MEM_AW];
    assign cnt_inc  = cnt + 9'd1;
    assign in_burst = (cnt <= {1'b0, len});
    assign s_axi_r_resp_o = RESP_OKAY;
    assign state_dbg      = state;

    // Byte-offset bits and bits above the RAM depth alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_aw_addr_i[OFF-1:0], s_axi_aw_addr_i[AXI_ADDR_WIDTH-1:OFF+MEM_AW],
                                s_axi_ar_addr_i[OFF-1:0], s_axi_ar_addr_i[AXI_ADDR_WIDTH-1:OFF+MEM_AW]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (aw_hs)      state_nxt = WDATA;
                else if (ar_hs) state_nxt = RDATA;
            end
            WDATA: if (w_hs && s_axi_w_last_i) state_nxt = WRESP;
            WRESP: if (b_hs) state_nxt = IDLE;
            RDATA: if (r_hs && s_axi_r_last_o) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axi_aw_ready_o = 1'b0;
        s_axi_ar_ready_o = 1'b0;
        s_axi_w_ready_o  = 1'b0;
        s_axi_b_valid_o  = 1'b0;
        s_axi_r_valid_o  = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    s_axi_aw_ready_o = aw_grant;
                    s_axi_ar_ready_o = s_axi_ar_valid_i & ~aw_grant;
                end
                WDATA:   s_axi_w_ready_o = 1'b1;
                WRESP:   s_axi_b_valid_o = 1'b1;
                RDATA:   s_axi_r_valid_o = 1'b1;
                default: ;
            endcase
        end
    end

    // Write counter saturates at 256 so any beat past the final one stays discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_w         <= 1'b1;
            idx            <= '0;
            len            <= '0;
            cnt            <= '0;
            s_axi_b_resp_o <= RESP_OKAY;
            s_axi_b_id_o   <= '0;
            s_axi_r_data_o <= '0;
            s_axi_r_last_o <= 1'b0;
            s_axi_r_id_o   <= '0;
        end else begin
            if (aw_hs) begin
                idx          <= aw_idx;
                len          <= s_axi_aw_len_i;
                cnt          <= '0;
                s_axi_b_id_o <= s_axi_aw_id_i;
            end else if (ar_hs) begin
                idx            <= ar_idx + 1'b1;
                len            <= s_axi_ar_len_i;
                cnt            <= '0;
                s_axi_r_id_o   <= s_axi_ar_id_i;
                s_axi_r_data_o <= mem[ar_idx];
                s_axi_r_last_o <= (s_axi_ar_len_i == 8'd0);
            end
            if (w_hs) begin
                if (in_burst)       idx <= idx + 1'b1;
                if (cnt != 9'h100)  cnt <= cnt_inc;
                if (s_axi_w_last_i)
                    s_axi_b_resp_o <= (cnt == {1'b0, len}) ? RESP_OKAY : RESP_SLVERR;
            end
            if (b_hs) prio_w <= 1'b0;
            if (r_hs) begin
                if (s_axi_r_last_o) begin
                    prio_w         <= 1'b1;
                    s_axi_r_last_o <= 1'b0;
                end else begin
                    s_axi_r_data_o <= mem[idx];
                    idx            <= idx + 1'b1;
                    cnt            <= cnt_inc;
                    s_axi_r_last_o <= (cnt_inc == {1'b0, len});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && in_burst) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_w_strb_i[b]) mem[idx][8*b +: 8] <= s_axi_w_data_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: bus driver tasks, a reference memory
// model, and scoreboard queues for B responses and R data.
module tb_axi_sram_slave;
    logic        clk;
    logic        rst;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [5:0]  b_exp_q[$];
    logic [63:0] mem_model [int];
    logic [63:0] wbuf [16];

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_aw_valid_i(aw_valid), .s_axi_aw_ready_o(aw_ready), .s_axi_aw_addr_i(aw_addr),
        .s_axi_aw_id_i(aw_id), .s_axi_aw_len_i(aw_len),
        .s_axi_w_valid_i(w_valid), .s_axi_w_ready_o(w_ready), .s_axi_w_data_i(w_data),
        .s_axi_w_strb_i(w_strb), .s_axi_w_last_i(w_last),
        .s_axi_b_valid_o(b_valid), .s_axi_b_ready_i(b_ready), .s_axi_b_resp_o(b_resp),
        .s_axi_b_id_o(b_id),
        .s_axi_ar_valid_i(ar_valid), .s_axi_ar_ready_o(ar_ready), .s_axi_ar_addr_i(ar_addr),
        .s_axi_ar_id_i(ar_id), .s_axi_ar_len_i(ar_len),
        .s_axi_r_valid_o(r_valid), .s_axi_r_ready_i(r_ready), .s_axi_r_data_o(r_data),
        .s_axi_r_resp_o(r_resp), .s_axi_r_last_o(r_last), .s_axi_r_id_o(r_id),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] strb);
        logic [63:0] res;
        res = old;
        for (int b = 0; b < 8; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        return res;
    endfunction

    function automatic int word_of(input logic [31:0] addr, input int beat);
        return (int'(addr[14:3]) + beat) % 4096;
    endfunction

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input int nbeats, input logic [7:0] strb);
        int guard;
        int w;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
        #1;
        guard = 0;
        while (!aw_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        check_eq("aw_handshake", aw_ready, 1);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            w_valid = 1'b1; w_data = wbuf[b]; w_strb = strb; w_last = (b == nbeats - 1);
            #1;
            check_eq("w_ready", w_ready, 1);
            if (b <= int'(len)) begin
                w = word_of(addr, b);
                mem_model[w] = merge(mem_model.exists(w) ? mem_model[w] : 64'h0, wbuf[b], strb);
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_exp_q.push_back({(nbeats - 1 == int'(len)) ? 2'b00 : 2'b10, id});
    endtask

    task automatic collect_b(input int hold);
        logic [5:0] e;
        int guard;
        e = b_exp_q.pop_front();
        b_ready = 1'b0;
        #1;
        guard = 0;
        while (!b_valid && guard < 20) begin @(negedge clk); #1; guard++; end
        check_eq("b_valid", b_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check_eq("b_hold_valid", b_valid, 1);
            check_eq("b_hold_resp_id", {b_resp, b_id}, e);
            @(negedge clk); #1;
        end
        check_eq("b_resp_id", {b_resp, b_id}, e);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        #1;
        check_eq("b_cleared", b_valid, 0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input bit toggle);
        int guard;
        int beat;
        logic [63:0] e;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len;
        #1;
        check_eq("r_valid_before_ar", r_valid, 0);
        guard = 0;
        while (!ar_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        check_eq("ar_handshake", ar_ready, 1);
        for (int b = 0; b <= int'(len); b++) exp_q.push_back(mem_model[word_of(addr, b)]);
        @(posedge clk); #1;
        check_eq("r_valid_latency", r_valid, 1);
        ar_valid = 1'b0;
        beat = 0;
        guard = 0;
        @(negedge clk);
        while (beat <= int'(len) && guard < 100) begin
            r_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (r_valid && r_ready) begin
                e = exp_q.pop_front();
                check_eq("r_data", r_data, e);
                check_eq("r_last", r_last, (beat == int'(len)));
                check_eq("r_id", r_id, id);
                check_eq("r_resp", r_resp, 0);
                beat++;
            end else begin
                check_eq("r_hold", {r_valid, r_last, r_data}, {1'b1, (beat == int'(len)), exp_q[0]});
            end
            @(negedge clk);
            guard++;
        end
        r_ready = 1'b0;
        #1;
        check_eq("r_beats", beat, int'(len) + 1);
        check_eq("r_done", r_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] ra;
        logic [7:0]  rl;
        rst = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        b_ready = 0; ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; r_ready = 0;
        repeat (3) @(negedge clk);
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1;
        check_eq("rst_aw_ready", aw_ready, 0);
        check_eq("rst_ar_ready", ar_ready, 0);
        aw_valid = 1'b0; ar_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_state", state_dbg, 0);
        check_eq("rst_valids", {w_ready, b_valid, r_valid}, 0);
        check_eq("rst_regs", {b_resp, b_id, r_last, r_id}, 0);
        check_eq("rst_r_data", r_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous AW/AR: write first, then read, then write again.
        @(negedge clk);
        aw_valid = 1; aw_addr = 32'h300; aw_id = 4'h1; aw_len = 0;
        ar_valid = 1; ar_addr = 32'h300; ar_id = 4'h2; ar_len = 0;
        #1;
        check_eq("arb1_aw_ready", aw_ready, 1);
        check_eq("arb1_ar_ready", ar_ready, 0);
        @(negedge clk);
        aw_valid = 0; w_valid = 1; w_data = 64'hA5A5_0000_1234_5678; w_strb = 8'hFF; w_last = 1;
        mem_model[96] = 64'hA5A5_0000_1234_5678;
        #1;
        check_eq("arb1_w_ready", w_ready, 1);
        @(negedge clk);
        w_valid = 0; w_last = 0; b_ready = 1;
        #1;
        check_eq("arb1_b", {b_valid, b_resp, b_id}, {1'b1, 2'b00, 4'h1});
        @(negedge clk);
        b_ready = 0; aw_valid = 1; aw_data_swap: begin aw_id = 4'h7; end
        #1;
        check_eq("arb2_ar_ready", ar_ready, 1);
        check_eq("arb2_aw_ready", aw_ready, 0);
        @(negedge clk);
        ar_valid = 0; r_ready = 1;
        #1;
        check_eq("arb2_r", {r_valid, r_last, r_id}, {1'b1, 1'b1, 4'h2});
        check_eq("arb2_r_data", r_data, mem_model[96]);
        @(negedge clk);
        r_ready = 0;
        #1;
        check_eq("arb3_aw_ready", aw_ready, 1);
        @(negedge clk);
        aw_valid = 0; w_valid = 1; w_data = 64'h0BAD_F00D_CAFE_0001; w_strb = 8'hFF; w_last = 1;
        mem_model[96] = 64'h0BAD_F00D_CAFE_0001;
        #1;
        check_eq("arb3_w_ready", w_ready, 1);
        @(negedge clk);
        w_valid = 0; w_last = 0; b_ready = 1;
        #1;
        check_eq("arb3_b", {b_valid, b_resp, b_id}, {1'b1, 2'b00, 4'h7});
        @(negedge clk);
        b_ready = 0;
        read_burst(32'h300, 4'h3, 8'd0, 1'b0);

        // Single-beat write/read.
        wbuf[0] = 64'h1122334455667788;
        write_burst(32'h100, 4'h3, 8'd0, 1, 8'hFF);
        collect_b(0);
        read_burst(32'h100, 4'h5, 8'd0, 1'b0);

        // Four-beat burst, read back with r_ready toggling.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
        write_burst(32'h0, 4'h2, 8'd3, 4, 8'hFF);
        collect_b(1);
        read_burst(32'h0, 4'h4, 8'd3, 1'b1);

        // Byte strobes.
        wbuf[0] = '1;
        write_burst(32'h8, 4'h1, 8'd0, 1, 8'hFF);
        collect_b(0);
        wbuf[0] = '0;
        write_burst(32'h8, 4'h1, 8'd0, 1, 8'h0F);
        collect_b(0);
        read_burst(32'h8, 4'h1, 8'd0, 1'b0);

        // Early w_last: SLVERR, response held while b_ready stays low.
        for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
        write_burst(32'h200, 4'h9, 8'd3, 2, 8'hFF);
        collect_b(3);
        read_burst(32'h200, 4'h9, 8'd1, 1'b0);

        // Late w_last: extra beat discarded, SLVERR.
        wbuf[0] = 64'hAAAA_0000_0000_0001; wbuf[1] = 64'hAAAA_0000_0000_0002;
        write_burst(32'h600, 4'hA, 8'd1, 2, 8'hFF);
        collect_b(0);
        wbuf[0] = 64'hBBBB_0000_0000_0001; wbuf[1] = 64'hBBBB_0000_0000_0002;
        write_burst(32'h600, 4'hB, 8'd0, 2, 8'hFF);
        collect_b(0);
        read_burst(32'h600, 4'hB, 8'd1, 1'b0);

        // Aliasing of upper/low address bits, and wrap at the top of the RAM.
        wbuf[0] = 64'hC0DE_C0DE_0000_0100;
        write_burst(32'hF000_8100, 4'h6, 8'd0, 1, 8'hFF);
        collect_b(0);
        read_burst(32'h0000_0105, 4'h6, 8'd0, 1'b0);
        wbuf[0] = 64'hEEEE_0000_0000_0FFF; wbuf[1] = 64'hEEEE_0000_0000_0000;
        write_burst(32'h7FF8, 4'h8, 8'd1, 2, 8'hFF);
        collect_b(0);
        read_burst(32'h7FF8, 4'h8, 8'd1, 1'b1);

        // Reset in the middle of a read burst.
        for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
        write_burst(32'h400, 4'h7, 8'd7, 8, 8'hFF);
        collect_b(0);
        @(negedge clk);
        ar_valid = 1; ar_addr = 32'h400; ar_id = 4'h6; ar_len = 8'd7;
        #1;
        check_eq("mid_ar_ready", ar_ready, 1);
        @(negedge clk);
        ar_valid = 0; r_ready = 1;
        #1;
        check_eq("mid_beat0", r_data, mem_model[128]);
        @(negedge clk); #1;
        check_eq("mid_beat1", r_data, mem_model[129]);
        @(negedge clk);
        r_ready = 0; rst = 1; ar_valid = 1; aw_valid = 1;
        #1;
        check_eq("mid_rst_readies", {aw_ready, ar_ready, w_ready}, 0);
        @(posedge clk); #1;
        check_eq("mid_rst_r_valid", r_valid, 0);
        check_eq("mid_rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 0; ar_valid = 0; aw_valid = 0;
        read_burst(32'h400, 4'hC, 8'd7, 1'b0);

        // Random full-width bursts.
        for (int t = 0; t < 6; t++) begin
            ra = 32'($urandom_range(0, 4095)) << 3;
            rl = 8'($urandom_range(0, 7));
            for (int i = 0; i <= int'(rl); i++) wbuf[i] = {$urandom, $urandom};
            write_burst(ra, 4'($urandom_range(0, 15)), rl, int'(rl) + 1, 8'hFF);
            collect_b($urandom_range(0, 2));
            read_burst(ra, 4'($urandom_range(0, 15)), rl, 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
